// File: rtl/fpu_cmd_queue_if.sv
// Register-port and FPU-port signal bundle for fpu_cmd_queue.
// The block itself connects through the slave modport; its environment uses master.
interface fpu_cmd_queue_if;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [1:0]  issue_sub;
  logic [2:0]  issue_frm;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [31:0] issue_c;

  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_exc;

  modport master (
    output wr_en, rd_en, addr, wr_data, fpu_done, fpu_result, fpu_exc,
    input  rd_data, issue_valid, issue_op, issue_sub, issue_frm, issue_a, issue_b, issue_c
  );

  modport slave (
    input  wr_en, rd_en, addr, wr_data, fpu_done, fpu_result, fpu_exc,
    output rd_data, issue_valid, issue_op, issue_sub, issue_frm, issue_a, issue_b, issue_c
  );
endinterface

// File: rtl/fpu_cmd_queue.sv
// Command-queued FPU sequencer: staging registers, command/result FIFOs and an issue FSM.
// Defining FPU_CMDQ_TIMEOUT_EN adds a WAIT-state watchdog that retires a stuck op.
module fpu_cmd_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic           clk,
  input  logic           rst_l,
  fpu_cmd_queue_if.slave bus,
  output logic           irq
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned RAW   = $clog2(RES_DEPTH);
  localparam int unsigned RW    = RAW + 1;
  localparam int unsigned CMD_W = 9 + TAG_W + 96;
  localparam int unsigned RES_W = 38 + TAG_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam logic [2:0] AddrOpa    = 3'd0;
  localparam logic [2:0] AddrOpb    = 3'd1;
  localparam logic [2:0] AddrOpc    = 3'd2;
  localparam logic [2:0] AddrCmd    = 3'd3;
  localparam logic [2:0] AddrResult = 3'd4;
  localparam logic [2:0] AddrLast   = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd6;
  localparam logic [2:0] AddrCtrl   = 3'd7;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_res_depth
    $error("RES_DEPTH must be a power of 2 and at least 2");
  end
  if (TAG_W < 1 || TAG_W > 8) begin : g_bad_tag_w
    $error("TAG_W must be in 1..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [31:0]      opa_q, opb_q, opc_q;

  logic [CMD_W-1:0] cq_mem [DEPTH];
  logic [AW-1:0]    cq_wptr_q, cq_rptr_q;
  logic [CW-1:0]    cq_cnt_q;
  logic             cq_full, cq_empty, cq_push, cq_pop;
  logic [CMD_W-1:0] cq_wdata, cq_head;

  logic [RES_W-1:0] rq_mem [RES_DEPTH];
  logic [RAW-1:0]   rq_wptr_q, rq_rptr_q;
  logic [RW-1:0]    rq_cnt_q;
  logic             rq_full, rq_empty, rq_push, rq_pop;
  logic [RES_W-1:0] rq_wdata, rq_head;

  logic [3:0]       op_q;
  logic [1:0]       sub_q;
  logic [2:0]       frm_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      a_q, b_q, c_q;
  logic             illegal;

  logic             ovf_q, udf_q, tmo_flag, sticky_clr, to_expired;
  logic [7:0]       thresh_q;
  logic [4:0]       last_exc_q;
  logic             last_ill_q;
  logic [TAG_W-1:0] last_tag_q;
  logic [31:0]      rd_data_q, rd_mux, status, last_word;
  logic             wr_cmd, wr_ctrl, rd_res, busy;

  assign wr_cmd     = bus.wr_en && (bus.addr == AddrCmd);
  assign wr_ctrl    = bus.wr_en && (bus.addr == AddrCtrl);
  assign rd_res     = bus.rd_en && (bus.addr == AddrResult);
  assign sticky_clr = wr_ctrl && bus.wr_data[31];

  assign cq_full  = (cq_cnt_q == CW'(DEPTH));
  assign cq_empty = (cq_cnt_q == '0);
  assign rq_full  = (rq_cnt_q == RW'(RES_DEPTH));
  assign rq_empty = (rq_cnt_q == '0);

  // A push on a full queue is dropped even when a pop happens on the same edge.
  assign cq_push  = wr_cmd && !cq_full;
  assign cq_pop   = (state_q == StIdle) && !cq_empty && !rq_full;
  assign rq_pop   = rd_res && !rq_empty;

  assign cq_wdata = {bus.wr_data[3:0], bus.wr_data[5:4], bus.wr_data[8:6],
                     bus.wr_data[8+TAG_W:9], opa_q, opb_q, opc_q};
  assign cq_head  = cq_mem[cq_rptr_q];
  assign rq_head  = rq_mem[rq_rptr_q];

  assign illegal  = (op_q >= 4'd11) || (((op_q == 4'd1) || (op_q == 4'd2)) && (sub_q == 2'd3));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      opa_q <= '0;
      opb_q <= '0;
      opc_q <= '0;
    end else if (bus.wr_en) begin
      if (bus.addr == AddrOpa) opa_q <= bus.wr_data;
      if (bus.addr == AddrOpb) opb_q <= bus.wr_data;
      if (bus.addr == AddrOpc) opc_q <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cq_wptr_q <= '0;
      cq_rptr_q <= '0;
      cq_cnt_q  <= '0;
    end else begin
      if (cq_push) cq_wptr_q <= cq_wptr_q + 1'b1;
      if (cq_pop)  cq_rptr_q <= cq_rptr_q + 1'b1;
      if (cq_push && !cq_pop)      cq_cnt_q <= cq_cnt_q + 1'b1;
      else if (!cq_push && cq_pop) cq_cnt_q <= cq_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wptr_q] <= cq_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rq_wptr_q <= '0;
      rq_rptr_q <= '0;
      rq_cnt_q  <= '0;
    end else begin
      if (rq_push) rq_wptr_q <= rq_wptr_q + 1'b1;
      if (rq_pop)  rq_rptr_q <= rq_rptr_q + 1'b1;
      if (rq_push && !rq_pop)      rq_cnt_q <= rq_cnt_q + 1'b1;
      else if (!rq_push && rq_pop) rq_cnt_q <= rq_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wptr_q] <= rq_wdata;
  end

  // The popped command stays latched here so issue_* are stable through WAIT.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      op_q  <= '0;
      sub_q <= '0;
      frm_q <= '0;
      tag_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else if (cq_pop) begin
      {op_q, sub_q, frm_q, tag_q, a_q, b_q, c_q} <= cq_head;
    end
  end

  always_comb begin
    state_d  = state_q;
    rq_push  = 1'b0;
    rq_wdata = '0;
    case (state_q)
      StIdle: begin
        if (cq_pop) state_d = StIssue;
      end
      StIssue: begin
        if (illegal) begin
          rq_push  = 1'b1;
          rq_wdata = {32'd0, 5'b10000, 1'b1, tag_q};
          state_d  = StIdle;
        end else if (bus.fpu_done) begin
          rq_push  = 1'b1;
          rq_wdata = {bus.fpu_result, bus.fpu_exc, 1'b0, tag_q};
          state_d  = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.fpu_done) begin
          rq_push  = 1'b1;
          rq_wdata = {bus.fpu_result, bus.fpu_exc, 1'b0, tag_q};
          state_d  = StIdle;
        end else if (to_expired) begin
          rq_push  = 1'b1;
          rq_wdata = {32'd0, 5'b10000, 1'b0, tag_q};
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= StIdle;
    else        state_q <= state_d;
  end

`ifdef FPU_CMDQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            tmo_q;

  assign to_expired = (state_q == StWait) && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign tmo_flag   = tmo_q;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == StWait) ? to_cnt_q + 1'b1 : '0;
      if (sticky_clr) tmo_q <= 1'b0;
      if (to_expired && !bus.fpu_done) tmo_q <= 1'b1;
    end
  end
`else
  assign to_expired = 1'b0;
  assign tmo_flag   = 1'b0;
`endif

  // Sticky set takes priority over a same-cycle CTRL clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      thresh_q <= '0;
    end else begin
      if (wr_ctrl) thresh_q <= bus.wr_data[7:0];
      if (sticky_clr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (wr_cmd && cq_full)  ovf_q <= 1'b1;
      if (rd_res && rq_empty) udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      last_exc_q <= '0;
      last_ill_q <= 1'b0;
      last_tag_q <= '0;
    end else if (rq_pop) begin
      last_exc_q <= rq_head[TAG_W+5 -: 5];
      last_ill_q <= rq_head[TAG_W];
      last_tag_q <= rq_head[TAG_W-1:0];
    end
  end

  assign busy      = (state_q != StIdle) || !cq_empty;
  assign status    = {12'd0, tmo_flag, udf_q, ovf_q, busy, 8'(rq_cnt_q), 8'(cq_cnt_q)};
  assign last_word = {{(24 - TAG_W){1'b0}}, last_tag_q, 2'b00, last_ill_q, last_exc_q};

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      AddrOpa:    rd_mux = opa_q;
      AddrOpb:    rd_mux = opb_q;
      AddrOpc:    rd_mux = opc_q;
      AddrResult: if (!rq_empty) rd_mux = rq_head[RES_W-1 -: 32];
      AddrLast:   rd_mux = last_word;
      AddrStatus: rd_mux = status;
      AddrCtrl:   rd_mux = {24'd0, thresh_q};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l)         rd_data_q <= '0;
    else if (bus.rd_en) rd_data_q <= rd_mux;
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.issue_valid = (state_q == StIssue) && !illegal;
  assign bus.issue_op    = op_q;
  assign bus.issue_sub   = sub_q;
  assign bus.issue_frm   = frm_q;
  assign bus.issue_a     = a_q;
  assign bus.issue_b     = b_q;
  assign bus.issue_c     = c_q;

  assign irq = ((8'(rq_cnt_q) >= thresh_q) && (thresh_q != 8'd0)) || ovf_q || udf_q || tmo_flag;

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Directed self-checking bench for fpu_cmd_queue with a latency-programmable FPU model.
module tb_fpu_cmd_queue;
  localparam logic [2:0] AddrOpa    = 3'd0;
  localparam logic [2:0] AddrOpb    = 3'd1;
  localparam logic [2:0] AddrCmd    = 3'd3;
  localparam logic [2:0] AddrResult = 3'd4;
  localparam logic [2:0] AddrLast   = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd6;
  localparam logic [2:0] AddrCtrl   = 3'd7;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic irq;

  fpu_cmd_queue_if bus ();

  fpu_cmd_queue dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // FPU model: done fpu_lat cycles after the issue cycle (0 = same cycle).
  int          fpu_lat = 0;
  int          cyc = 0;
  bit          act = 1'b0;
  bit          force_done = 1'b0;
  logic [31:0] res_val = '0;
  logic [4:0]  exc_val = '0;
  int          iv_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] d;
  int          base;
  bit          ok;

  assign bus.fpu_result = res_val;
  assign bus.fpu_exc    = exc_val;
  assign bus.fpu_done   = force_done || (bus.issue_valid && fpu_lat == 0) ||
                          (act && cyc == fpu_lat);

  always @(posedge clk) begin
    if (bus.issue_valid) begin
      iv_cnt <= iv_cnt + 1;
      act    <= (fpu_lat > 0);
      cyc    <= 1;
    end else if (act) begin
      if (cyc == fpu_lat) act <= 1'b0;
      else                cyc <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] v);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = v;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] v);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    tick(1);
    bus.rd_en = 1'b0;
    v = bus.rd_data;
  endtask

  task automatic pulse_done();
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
  endtask

  function automatic logic [31:0] cmd(input int unsigned op, input int unsigned sub,
                                      input int unsigned frm, input int unsigned tag);
    return 32'((op & 15) | ((sub & 3) << 4) | ((frm & 7) << 6) | (tag << 9));
  endfunction

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr = '0;
    bus.wr_data = '0;

    tick(2);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_issue_a", bus.issue_a, 32'h0);
    rst_l = 1'b1;
    tick(1);
    reg_rd(AddrStatus, d); check("rst_status", d, 32'h0);
    reg_rd(AddrOpa, d);    check("rst_opa", d, 32'h0);

    // Single-cycle op completing in its issue cycle
    fpu_lat = 0; res_val = 32'h4040_0000; exc_val = 5'b0;
    reg_wr(AddrOpa, 32'h3F80_0000);
    reg_wr(AddrOpb, 32'h4000_0000);
    base = iv_cnt;
    reg_wr(AddrCmd, cmd(6, 0, 2, 3));
    tick(1);
    check("s_issue_valid", 32'(bus.issue_valid), 32'h1);
    check("s_issue_op", 32'(bus.issue_op), 32'h6);
    check("s_issue_frm", 32'(bus.issue_frm), 32'h2);
    check("s_issue_a", bus.issue_a, 32'h3F80_0000);
    check("s_issue_b", bus.issue_b, 32'h4000_0000);
    tick(1);
    reg_rd(AddrStatus, d); check("s_status", d, 32'h0000_0100);
    check("s_issue_pulses", 32'(iv_cnt - base), 32'h1);
    reg_rd(AddrResult, d); check("s_result", d, 32'h4040_0000);
    reg_rd(AddrLast, d);   check("s_last", d, 32'h0000_0300);
    reg_rd(AddrStatus, d); check("s_status_empty", d, 32'h0);

    // Multi-cycle op, done 25 cycles after ISSUE: entry lands at edge N+27
    fpu_lat = 25; res_val = 32'h1234_5678; exc_val = 5'b01000;
    reg_wr(AddrCmd, cmd(9, 0, 0, 5));
    ok = 1'b1;
    for (int i = 0; i < 27; i++) begin
      reg_rd(AddrStatus, d);
      if (!d[16] || d[15:8] != 8'd0) ok = 1'b0;
    end
    check("m_busy_no_result", 32'(ok), 32'h1);
    reg_rd(AddrStatus, d); check("m_status_done", d, 32'h0000_0100);
    reg_rd(AddrResult, d); check("m_result", d, 32'h1234_5678);
    reg_rd(AddrLast, d);   check("m_last", d, 32'h0000_0508);

    // Command FIFO full: one in flight, four queued, the sixth write is dropped
    fpu_lat = 1000; res_val = 32'h0000_00F0; exc_val = 5'b0;
    for (int i = 1; i <= 6; i++) reg_wr(AddrCmd, cmd(0, 0, 0, i));
    check("f_irq_ovf", 32'(irq), 32'h1);
    reg_rd(AddrStatus, d); check("f_status_ovf", d, 32'h0003_0004);
    reg_wr(AddrCtrl, 32'h8000_0000);
    check("f_irq_clr", 32'(irq), 32'h0);
    reg_rd(AddrStatus, d); check("f_status_clr", d, 32'h0001_0004);
    fpu_lat = 0;
    pulse_done();
    tick(10);
    reg_rd(AddrStatus, d); check("f_res_full_stall", d, 32'h0001_0401);
    for (int i = 0; i < 4; i++) begin
      reg_rd(AddrResult, d); check("f_drain", d, 32'h0000_00F0);
    end
    tick(3);
    reg_rd(AddrResult, d); check("f_last_result", d, 32'h0000_00F0);
    reg_rd(AddrStatus, d); check("f_status_idle", d, 32'h0);

    // Illegal ops: no issue, error entry with illegal flag
    base = iv_cnt;
    reg_wr(AddrCmd, cmd(2, 3, 0, 7));
    tick(3);
    check("i_no_issue", 32'(iv_cnt - base), 32'h0);
    reg_rd(AddrResult, d); check("i_result", d, 32'h0);
    reg_rd(AddrLast, d);   check("i_last", d, 32'h0000_0730);
    reg_wr(AddrCmd, cmd(12, 0, 0, 1));
    tick(3);
    reg_rd(AddrResult, d); check("i_result_op12", d, 32'h0);
    reg_rd(AddrLast, d);   check("i_last_op12", d, 32'h0000_0130);
    check("i_no_issue_op12", 32'(iv_cnt - base), 32'h0);
    reg_rd(AddrStatus, d); check("i_status", d, 32'h0);

    // Threshold irq, then underflow on the third read
    res_val = 32'hAAAA_0001;
    reg_wr(AddrCtrl, 32'h0000_0002);
    reg_wr(AddrCmd, cmd(6, 0, 0, 1));
    reg_wr(AddrCmd, cmd(6, 0, 0, 2));
    tick(1);
    check("t_irq_one", 32'(irq), 32'h0);
    tick(2);
    check("t_irq_two", 32'(irq), 32'h1);
    reg_rd(AddrResult, d); check("t_result1", d, 32'hAAAA_0001);
    reg_rd(AddrResult, d); check("t_result2", d, 32'hAAAA_0001);
    reg_rd(AddrResult, d); check("t_result_empty", d, 32'h0);
    reg_rd(AddrLast, d);   check("t_last_kept", d, 32'h0000_0200);
    reg_rd(AddrStatus, d); check("t_status_udf", d, 32'h0004_0000);
    check("t_irq_udf", 32'(irq), 32'h1);

    // Reset mid-operation; a late done must be ignored
    reg_wr(AddrOpa, 32'h1111_1111);
    fpu_lat = 1000;
    reg_wr(AddrCmd, cmd(6, 0, 0, 4));
    tick(3);
    check("r_operand_held", bus.issue_a, 32'h1111_1111);
    rst_l = 1'b0;
    tick(1);
    rst_l = 1'b1;
    check("r_irq", 32'(irq), 32'h0);
    check("r_issue_valid", 32'(bus.issue_valid), 32'h0);
    check("r_issue_a", bus.issue_a, 32'h0);
    check("r_rd_data", bus.rd_data, 32'h0);
    pulse_done();
    tick(2);
    reg_rd(AddrStatus, d); check("r_status", d, 32'h0);
    reg_rd(AddrOpa, d);    check("r_opa", d, 32'h0);

    // Op that never completes
    res_val = 32'h5555_0000;
    reg_wr(AddrCmd, cmd(10, 0, 0, 6));
`ifdef FPU_CMDQ_TIMEOUT_EN
    tick(65);
    reg_rd(AddrStatus, d); check("to_waiting", d, 32'h0001_0000);
    reg_rd(AddrStatus, d); check("to_status", d, 32'h0008_0100);
    check("to_irq", 32'(irq), 32'h1);
    reg_rd(AddrResult, d); check("to_result", d, 32'h0);
    reg_rd(AddrLast, d);   check("to_last", d, 32'h0000_0610);
`else
    tick(70);
    reg_rd(AddrStatus, d); check("nt_waiting", d, 32'h0001_0000);
    pulse_done();
    reg_rd(AddrResult, d); check("nt_result", d, 32'h5555_0000);
    reg_rd(AddrLast, d);   check("nt_last", d, 32'h0000_0600);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
